// File: rtl/jk_excitation_driver_if.sv
// Handshake, excitation and status bundle between control logic, this driver and the JK bank.
// The slave modport is the driver's view; master is the controller/bank side.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             done;
  logic             err;
  logic             err_clr;
  logic             busy;

  modport slave (
    input  in_valid, in_data, q_fb, err_clr,
    output in_ready, j_out, k_out, done, err, busy
  );

  modport master (
    output in_valid, in_data, q_fb, err_clr,
    input  in_ready, j_out, k_out, done, err, busy
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Write-side driver for a JK flip-flop bank: pulses one cycle of J/K excitation toward a
// target word, verifies the fed-back Q and retries up to MAX_RETRY times before flagging err.
module jk_excitation_driver #(
  parameter int WIDTH      = 8,
  parameter bit TOGGLE_EXC = 1'b0,
  parameter int MAX_RETRY  = 3
) (
  input logic                   clk,
  input logic                   rst,
  jk_excitation_driver_if.slave bus
);
  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] RETRY_LIM = CW'(MAX_RETRY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] target;
  logic [CW-1:0]    retry_cnt;
  logic [WIDTH-1:0] j_q, k_q;
  logic             done_q, err_q, ready_q, busy_q;

  logic [WIDTH-1:0] exc_tgt, exc_diff, j_calc, k_calc;

  // In IDLE the excitation is computed from the word being accepted; on retry from the latched target.
  // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    exc_tgt  = (state == S_IDLE) ? bus.in_data : target;
    exc_diff = exc_tgt ^ bus.q_fb;
    if (TOGGLE_EXC) begin
      j_calc = exc_diff;
      k_calc = exc_diff;
    end else begin
      j_calc = exc_diff & exc_tgt;
      k_calc = exc_diff & ~exc_tgt;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      target    <= '0;
      retry_cnt <= '0;
      j_q       <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      // Excitation and done are single-cycle pulses unless a branch re-arms them.
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            target    <= bus.in_data;
            j_q       <= j_calc;
            k_q       <= k_calc;
            retry_cnt <= '0;
            state     <= S_DRIVE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_DRIVE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.q_fb == target) begin
            done_q  <= 1'b1;
            state   <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (retry_cnt < RETRY_LIM) begin
            retry_cnt <= retry_cnt + CW'(1);
            j_q       <= j_calc;
            k_q       <= k_calc;
            state     <= S_DRIVE;
          end else begin
            err_q  <= 1'b1;
            state  <= S_ERR;
            busy_q <= 1'b0;
          end
        end
        S_ERR: begin
          if (bus.err_clr) begin
            err_q   <= 1'b0;
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.j_out    = j_q;
  assign bus.k_out    = k_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: a set/clear and a toggle instance run in lockstep on
// identical JK bank models; a transaction-level model predicts excitation, retries and status.
module tb_jk_excitation_driver;
  localparam int W  = 8;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jk_excitation_driver_if #(.WIDTH(W)) b0 ();
  jk_excitation_driver_if #(.WIDTH(W)) b1 ();

  jk_excitation_driver #(.WIDTH(W), .TOGGLE_EXC(1'b0), .MAX_RETRY(MR)) u_dut_set (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  jk_excitation_driver #(.WIDTH(W), .TOGGLE_EXC(1'b1), .MAX_RETRY(MR)) u_dut_tog (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  // JK bank models: bits in stuck are held at 0 regardless of excitation.
  logic [W-1:0] bank0, bank1, stuck, load_val;
  logic         load;

  always @(posedge clk) begin
    if (load) begin
      bank0 <= load_val & ~stuck;
      bank1 <= load_val & ~stuck;
    end else begin
      bank0 <= ((b0.j_out & ~bank0) | (~b0.k_out & bank0)) & ~stuck;
      bank1 <= ((b1.j_out & ~bank1) | (~b1.k_out & bank1)) & ~stuck;
    end
  end

  assign b0.q_fb = bank0;
  assign b1.q_fb = bank1;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] mq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [W-1:0] data, input logic clr);
    b0.in_valid = valid;
    b1.in_valid = valid;
    b0.in_data  = data;
    b1.in_data  = data;
    b0.err_clr  = clr;
    b1.err_clr  = clr;
  endtask

  // Expected {j,k} straight from the excitation table.
  function automatic logic [2*W-1:0] exc(input logic [W-1:0] tgt, input logic [W-1:0] q,
                                         input bit tog);
    logic [W-1:0] d;
    d = tgt ^ q;
    return tog ? {d, d} : {d & tgt, d & ~tgt};
  endfunction

  task automatic check_status(input string tag, input logic rdy, input logic bsy,
                              input logic dn, input logic er);
    check({tag, ".rdy0"},  32'(b0.in_ready), 32'(rdy));
    check({tag, ".rdy1"},  32'(b1.in_ready), 32'(rdy));
    check({tag, ".busy0"}, 32'(b0.busy),     32'(bsy));
    check({tag, ".busy1"}, 32'(b1.busy),     32'(bsy));
    check({tag, ".done0"}, 32'(b0.done),     32'(dn));
    check({tag, ".done1"}, 32'(b1.done),     32'(dn));
    check({tag, ".err0"},  32'(b0.err),      32'(er));
    check({tag, ".err1"},  32'(b1.err),      32'(er));
  endtask

  task automatic check_jk(input string tag, input logic [2*W-1:0] e0, input logic [2*W-1:0] e1);
    check({tag, ".jk0"}, 32'({b0.j_out, b0.k_out}), 32'(e0));
    check({tag, ".jk1"}, 32'({b1.j_out, b1.k_out}), 32'(e1));
  endtask

  // Called at a negedge with both DUTs idle; loads both banks during a quiet cycle.
  task automatic set_bank(input logic [W-1:0] val, input logic [W-1:0] stk);
    drive(1'b0, '0, 1'b0);
    stuck    = stk;
    load_val = val;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    mq   = val & ~stk;
  endtask

  // One transaction from an idle negedge. With hold=1 in_valid stays high throughout
  // (in_data scrambled) and the caller must issue the next word at the returning negedge.
  task automatic run_txn(input string tag, input logic [W-1:0] tgt, input bit hold);
    logic [W-1:0] q;
    bit           ok;
    int           attempts;
    check({tag, ".accept_rdy"}, 32'(b0.in_ready & b1.in_ready), 32'(1));
    drive(1'b1, tgt, 1'b0);
    q        = mq;
    ok       = ((tgt & ~stuck) == tgt);
    attempts = ok ? 1 : MR + 1;
    for (int a = 0; a < attempts; a++) begin
      @(negedge clk);
      if (a == 0) drive(hold, W'($urandom), 1'b0);
      check_jk({tag, ".drive"}, exc(tgt, q, 1'b0), exc(tgt, q, 1'b1));
      check_status({tag, ".drive"}, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_jk({tag, ".check"}, '0, '0);
      check_status({tag, ".check"}, 1'b0, 1'b1, 1'b0, 1'b0);
      q = tgt & ~stuck;
    end
    @(negedge clk);
    mq = q;
    check({tag, ".bank0"}, 32'(bank0), 32'(mq));
    check({tag, ".bank1"}, 32'(bank1), 32'(mq));
    check_jk({tag, ".end"}, '0, '0);
    if (ok) begin
      check_status({tag, ".done"}, 1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      check_status({tag, ".err"}, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check_status({tag, ".err_sticky"}, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(hold, W'($urandom), 1'b1);
      @(negedge clk);
      drive(1'b0, '0, 1'b0);
      check_status({tag, ".err_clr"}, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_mid_drive(input logic [W-1:0] tgt);
    drive(1'b1, tgt, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    check_jk("rst.pre", exc(tgt, mq, 1'b0), exc(tgt, mq, 1'b1));
    rst = 1'b0;
    #1;
    check_jk("rst.async", '0, '0);
    check_status("rst.async", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_jk("rst.after", '0, '0);
    check_status("rst.after", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.bank0", 32'(bank0), 32'(mq));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tgt, stk;
    bit           hold;
    drive(1'b0, '0, 1'b0);
    stuck    = '0;
    load_val = '0;
    load     = 1'b1;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    check_jk("reset", '0, '0);
    check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    rst  = 1'b1;
    load = 1'b0;
    mq   = '0;
    @(negedge clk);

    run_txn("t1_a5", 8'hA5, 1'b0);
    set_bank(8'hF0, 8'h00);
    run_txn("t2_0f", 8'h0F, 1'b0);
    set_bank(8'h3C, 8'h00);
    run_txn("t3_same", 8'h3C, 1'b0);
    set_bank(8'h00, 8'h01);
    run_txn("t4_stuck", 8'h01, 1'b0);
    set_bank(8'h00, 8'h00);

    // err_clr outside ERR has no effect.
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    check_status("clr_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    reset_mid_drive(8'h5A);
    run_txn("t6_11", 8'h11, 1'b1);
    run_txn("t6_22", 8'h22, 1'b0);

    for (int i = 0; i < 24; i++) begin
      stk = ($urandom_range(0, 3) == 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
      if (stk != stuck || $urandom_range(0, 2) == 0) set_bank(W'($urandom), stk);
      tgt  = ($urandom_range(0, 5) == 0) ? mq : W'($urandom);
      hold = ($urandom_range(0, 1) == 1) && (i != 23);
      run_txn($sformatf("rnd%0d", i), tgt, hold);
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check_status("final", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
